// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon seed, key-schedule states and
// small word/byte helpers used by the key schedule and round datapath.
package aes_pkg;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE,
        ROUND
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup (forward direction), one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    // Row r of the table holds S-box entries 16*r .. 16*r+15, index 0 in the top byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_o = SBOX[sub_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: latches the cipher key on start and hands
// out round keys 0..NR one per valid/ready handshake, with Rcon kept locally.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         round_valid,
    input  logic         round_ready,
    output logic         busy,
    output logic         done
);

    if (NR != NR_AES128) begin : g_bad_nr
        $error("aes_key_schedule: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_t    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub, temp;
    logic [31:0]  w4, w5, w6, w7;

    assign {w0, w1, w2, w3} = key_q;
    assign rot = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .sub_i (rot[8*i +: 8]),
            .sub_o (sub[8*i +: 8])
        );
    end

    assign temp = sub ^ {rcon_q, 24'h0};
    assign w4   = w0 ^ temp;
    assign w5   = w4 ^ w1;
    assign w6   = w5 ^ w2;
    assign w7   = w6 ^ w3;

    // Round key advances only on a handshake; a stalled consumer freezes everything.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROUND;
                    key_d   = key;
                    idx_d   = 4'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            ROUND: begin
                if (round_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d  = {w4, w5, w6, w7};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign round_key   = key_q;
    assign round_idx   = idx_q;
    assign round_valid = (state_q == ROUND);
    assign busy        = (state_q == ROUND);
    assign done        = done_q;

endmodule
